// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel double-buffered PWM generator with shared period counter
module pwm_multi #(
  parameter int W        = 8,
  parameter int NCH      = 4,
  parameter int PRESC    = 1,
  parameter int CENTER   = 0,
  parameter int POLARITY = 1,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [W-1:0]   period,
  input  logic           duty_wr,
  input  logic [CHW-1:0] duty_ch,
  input  logic [W-1:0]   duty_val,
  output logic [NCH-1:0] pwm_out,
  output logic           period_start,
  output logic [W-1:0]   cnt
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [NCH-1:0] IDLE = (POLARITY != 0) ? {NCH{1'b0}} : {NCH{1'b1}};

  logic [PW-1:0]  presc_q;
  logic [W-1:0]   pa_q;
  logic           dir_down_q;
  logic [W-1:0]   shadow_q [NCH];
  logic [W-1:0]   active_q [NCH];

  logic           tick;
  logic           reload;
  logic           ch_ok;
  logic           dir_down_nxt;
  logic [W-1:0]   cnt_nxt;
  logic [NCH-1:0] raw;

  always_comb begin
    tick         = (presc_q == PRESC_LAST);
    cnt_nxt      = cnt;
    dir_down_nxt = dir_down_q;
    if (CENTER != 0) begin
      // Turn around at the top; a period of 0 or 1 collapses straight back to 0.
      if (!dir_down_q) begin
        if (cnt >= pa_q) begin
          cnt_nxt      = (cnt == '0) ? '0 : cnt - W'(1);
          dir_down_nxt = (cnt_nxt != '0);
        end else begin
          cnt_nxt = cnt + W'(1);
        end
      end else begin
        cnt_nxt      = cnt - W'(1);
        dir_down_nxt = (cnt_nxt != '0);
      end
    end else begin
      cnt_nxt = (cnt >= pa_q) ? '0 : cnt + W'(1);
    end
    reload = tick && (cnt_nxt == '0);
    ch_ok  = (int'(duty_ch) < NCH);
    for (int i = 0; i < NCH; i++) begin
      raw[i] = (cnt < active_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      cnt          <= '0;
      pa_q         <= '0;
      dir_down_q   <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= IDLE;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (duty_wr && ch_ok) begin
        shadow_q[duty_ch] <= duty_val;
      end
      if (!enable) begin
        // While idle the active registers track the shadows so new settings apply at once.
        presc_q      <= '0;
        cnt          <= '0;
        dir_down_q   <= 1'b0;
        period_start <= 1'b0;
        pwm_out      <= IDLE;
        pa_q         <= period;
        for (int i = 0; i < NCH; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end else begin
        presc_q      <= tick ? '0 : presc_q + PW'(1);
        pwm_out      <= (POLARITY != 0) ? raw : ~raw;
        period_start <= reload;
        if (tick) begin
          cnt        <= cnt_nxt;
          dir_down_q <= dir_down_nxt;
        end
        if (reload) begin
          pa_q <= period;
          for (int i = 0; i < NCH; i++) begin
            active_q[i] <= shadow_q[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - bench for pwm_multi: duty/period table, directed corner sequences, random vs model
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] period;
  logic       duty_wr;
  logic [1:0] duty_ch;
  logic [7:0] duty_val;
  logic [3:0] pwm_w [3];
  logic       ps_w  [3];
  logic [7:0] cnt_w [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_multi #(.W(8), .NCH(4), .PRESC(1), .CENTER(0), .POLARITY(1)) u_edge (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .duty_wr(duty_wr),
    .duty_ch(duty_ch), .duty_val(duty_val), .pwm_out(pwm_w[0]), .period_start(ps_w[0]), .cnt(cnt_w[0]));
  pwm_multi #(.W(8), .NCH(4), .PRESC(3), .CENTER(0), .POLARITY(0)) u_presc (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .duty_wr(duty_wr),
    .duty_ch(duty_ch), .duty_val(duty_val), .pwm_out(pwm_w[1]), .period_start(ps_w[1]), .cnt(cnt_w[1]));
  pwm_multi #(.W(8), .NCH(4), .PRESC(1), .CENTER(1), .POLARITY(1)) u_center (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .duty_wr(duty_wr),
    .duty_ch(duty_ch), .duty_val(duty_val), .pwm_out(pwm_w[2]), .period_start(ps_w[2]), .cnt(cnt_w[2]));

  function automatic int presc_of(input int i); return (i == 1) ? 3 : 1; endfunction
  function automatic bit pol_of(input int i); return (i != 1); endfunction
  function automatic bit cen_of(input int i); return (i == 2); endfunction
  function automatic int idle_of(input int i); return pol_of(i) ? 0 : 15; endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [9:0]      p;
    logic [3:0][9:0] d;
    logic [3:0][9:0] e_hi;
    logic [3:0][9:0] c_hi;
    logic [9:0]      e_len;
    logic [9:0]      c_len;
  } row_t;

  function automatic row_t mkrow(input int p, input int d0, input int d1, input int d2, input int d3,
                                 input int e0, input int e1, input int e2, input int e3,
                                 input int c0, input int c1, input int c2, input int c3,
                                 input int el, input int cl);
    row_t r;
    r.p = 10'(p);
    r.d[0] = 10'(d0); r.d[1] = 10'(d1); r.d[2] = 10'(d2); r.d[3] = 10'(d3);
    r.e_hi[0] = 10'(e0); r.e_hi[1] = 10'(e1); r.e_hi[2] = 10'(e2); r.e_hi[3] = 10'(e3);
    r.c_hi[0] = 10'(c0); r.c_hi[1] = 10'(c1); r.c_hi[2] = 10'(c2); r.c_hi[3] = 10'(c3);
    r.e_len = 10'(el);
    r.c_len = 10'(cl);
    return r;
  endfunction

  task automatic write_ch(input int ch, input int v);
    duty_ch  = 2'(ch);
    duty_val = 8'(v);
    duty_wr  = 1'b1;
    @(negedge clk);
    duty_wr  = 1'b0;
  endtask

  task automatic wait_ps(input int i);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!ps_w[i] && g < 3000);
    chk($sformatf("wait_ps%0d", i), int'(ps_w[i]), 1);
  endtask

  task automatic wait_cnt(input int i, input int v);
    int g = 0;
    while (int'(cnt_w[i]) != v && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("wait_cnt%0d", i), int'(cnt_w[i]), v);
  endtask

  // Active clocks per channel over one full cycle, window opened by period_start.
  int m_len;
  int m_hi [4];
  task automatic measure(input int i);
    int g = 0;
    while (!ps_w[i] && g < 3000) begin
      @(negedge clk);
      g++;
    end
    m_len = 0;
    for (int c = 0; c < 4; c++) m_hi[c] = 0;
    do begin
      for (int c = 0; c < 4; c++) if (pwm_w[i][c] == pol_of(i)) m_hi[c]++;
      m_len++;
      @(negedge clk);
    end while (!ps_w[i] && m_len < 3000);
  endtask

  // Reference model: position k within a cycle of L ticks; cnt derived from k.
  int mq [3], mtk [3], mpa [3], mo [3], mps [3];
  int mact [3][4], mshad [3][4];

  function automatic int cnt_of(input int i);
    if (cen_of(i) && mtk[i] > mpa[i]) return 2 * mpa[i] - mtk[i];
    return mtk[i];
  endfunction

  task automatic model_reset(input int i);
    mq[i] = 0; mtk[i] = 0; mpa[i] = 0; mps[i] = 0; mo[i] = idle_of(i);
    for (int c = 0; c < 4; c++) begin mact[i][c] = 0; mshad[i][c] = 0; end
  endtask

  task automatic model_step(input int i);
    int c, o, len;
    if (!rst_n) begin
      model_reset(i);
      return;
    end
    if (!enable) begin
      for (int ch = 0; ch < 4; ch++) mact[i][ch] = mshad[i][ch];
      mpa[i] = int'(period); mq[i] = 0; mtk[i] = 0; mps[i] = 0; mo[i] = idle_of(i);
    end else begin
      c = cnt_of(i);
      o = 0;
      for (int ch = 0; ch < 4; ch++) if ((c < mact[i][ch]) == pol_of(i)) o |= (1 << ch);
      mo[i]  = o;
      mps[i] = 0;
      if (mq[i] == presc_of(i) - 1) begin
        mq[i] = 0;
        len = cen_of(i) ? ((mpa[i] == 0) ? 1 : 2 * mpa[i]) : mpa[i] + 1;
        mtk[i] = (mtk[i] + 1) % len;
        if (mtk[i] == 0) begin
          for (int ch = 0; ch < 4; ch++) mact[i][ch] = mshad[i][ch];
          mpa[i] = int'(period);
          mps[i] = 1;
        end
      end else begin
        mq[i]++;
      end
    end
    if (duty_wr) mshad[i][duty_ch] = int'(duty_val);
  endtask

  row_t rows [4];
  int   cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

  initial begin
    int t, hcnt;
    rst_n = 1'b0; enable = 1'b0; period = '0;
    duty_wr = 1'b0; duty_ch = '0; duty_val = '0;

    rows[0] = mkrow(9,   0, 3, 10, 9,      0, 3, 10, 9,      0, 5, 18, 17,    10, 18);
    rows[1] = mkrow(4,   2, 5, 0, 4,       2, 5, 0, 4,       3, 8, 0, 7,      5, 8);
    rows[2] = mkrow(1,   1, 2, 0, 255,     1, 2, 0, 2,       1, 2, 0, 2,      2, 2);
    rows[3] = mkrow(255, 128, 255, 1, 0,   128, 255, 1, 0,   255, 509, 1, 0,  256, 510);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 4; r++) begin
      enable = 1'b0;
      @(negedge clk);
      period = rows[r].p[7:0];
      for (int c = 0; c < 4; c++) write_ch(c, int'(rows[r].d[c]));
      @(negedge clk);
      chk("idle_pwm0", int'(pwm_w[0]), 0);
      chk("idle_pwm1", int'(pwm_w[1]), 15);
      chk("idle_ps2",  int'(ps_w[2]), 0);
      chk("idle_cnt2", int'(cnt_w[2]), 0);
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
        measure(i);
        if (i == 2) chk($sformatf("r%0d_len%0d", r, i), m_len, int'(rows[r].c_len));
        else        chk($sformatf("r%0d_len%0d", r, i), m_len, presc_of(i) * int'(rows[r].e_len));
        for (int c = 0; c < 4; c++) begin
          if (i == 2) chk($sformatf("r%0d_hi%0d_ch%0d", r, i, c), m_hi[c], int'(rows[r].c_hi[c]));
          else        chk($sformatf("r%0d_hi%0d_ch%0d", r, i, c), m_hi[c], presc_of(i) * int'(rows[r].e_hi[c]));
        end
      end
    end

    // Double buffering on the edge instance: mid-cycle write, then write on the reload edge.
    enable = 1'b0;
    @(negedge clk);
    period = 8'd9;
    write_ch(1, 3);
    @(negedge clk);
    enable = 1'b1;
    wait_ps(0);
    wait_cnt(0, 4);
    write_ch(1, 7);
    hcnt = 0; t = 0;
    while (!ps_w[0] && t < 100) begin
      if (pwm_w[0][1]) hcnt++;
      @(negedge clk);
      t++;
    end
    chk("dbuf_cur_hi", hcnt, 0);
    measure(0);
    chk("dbuf_next_hi", m_hi[1], 7);
    chk("dbuf_next_len", m_len, 10);
    wait_cnt(0, 9);
    write_ch(1, 2);
    chk("dbuf_reload_ps", int'(ps_w[0]), 1);
    measure(0);
    chk("dbuf_reload_old", m_hi[1], 7);
    measure(0);
    chk("dbuf_reload_new", m_hi[1], 2);

    // Prescaled instance: period change mid-cycle applies only after the current reload.
    period = 8'd4;
    wait_ps(1);
    wait_ps(1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (t == 4) period = 8'd1;
    end while (!ps_w[1] && t < 100);
    chk("presc_cur_len", t, 15);
    measure(1);
    chk("presc_new_len", m_len, 6);

    // Center instance: counter trajectory over one cycle.
    period = 8'd4;
    wait_ps(2);
    wait_ps(2);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("center_cnt%0d", k), int'(cnt_w[2]), cseq[k]);
      @(negedge clk);
    end
    chk("center_ps", int'(ps_w[2]), 1);

    // Inverted polarity: idle high, then ch0 active-low for the first 2 ticks after enable.
    enable = 1'b0;
    period = 8'd4;
    @(negedge clk);
    write_ch(0, 2);
    @(negedge clk);
    chk("pol_idle", int'(pwm_w[1]), 15);
    enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("pol_start%0d", k), int'(pwm_w[1][0]), (k <= 6) ? 0 : 1);
    end

    // Asynchronous reset mid-run, checked between clock edges.
    wait_cnt(0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cnt0", int'(cnt_w[0]), 0);
    chk("rst_pwm0", int'(pwm_w[0]), 0);
    chk("rst_pwm1", int'(pwm_w[1]), 15);
    chk("rst_ps0",  int'(ps_w[0]), 0);
    chk("rst_cnt2", int'(cnt_w[2]), 0);
    for (int i = 0; i < 3; i++) model_reset(i);

    // Random traffic on all three instances against the model.
    for (int it = 0; it < 4000; it++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      for (int i = 0; i < 3; i++)
        chk($sformatf("rand%0d_it%0d", i, it),
            int'({cnt_w[i], ps_w[i], pwm_w[i]}),
            (cnt_of(i) << 5) | (mps[i] << 4) | mo[i]);
      if (bad > 20) break;
      if (it == 2 || it == 2004) rst_n = 1'b1;
      if (it == 2000) rst_n = 1'b0;
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 99) < 3) period = 8'($urandom_range(0, 12));
      duty_wr  = ($urandom_range(0, 3) == 0);
      duty_ch  = 2'($urandom_range(0, 3));
      duty_val = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 14));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
